// File: rtl/alu_op_ctrl.sv
// alu_op_ctrl
//   Multi-cycle sequencer for the LC-3 operate instructions ADD, AND and NOT.
//   An instruction is taken on a valid/ready handshake. The controller reads the
//   source registers, runs the external combinational ALU, and writes the result
//   back to the destination register while updating the N/Z/P condition codes.
//
//   Optional build macro: ALU_CTRL_STRICT_DECODE_EN
//     When defined, the reserved encodings below are rejected as illegal:
//       - NOT with instr[5:0] != 6'b111111
//       - ADD/AND register form with instr[4:3] != 2'b00
//     When undefined, those bits are ignored and the instruction executes.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   instr_valid/ready   instruction handshake; instr is the 16-bit word
//   rf_sr1, rf_sr2      register-file read addresses (latched instr[8:6], [2:0])
//   rf_ra, rf_rb        register-file read data (combinational)
//   alu_ra, alu_rb      ALU operands
//   alu_ir              ALU immediate/mode field (latched instr[5:0])
//   alu_control         00 pass A, 01 A+B, 10 A&B, 11 ~A
//   alu_result          ALU output (combinational)
//   rf_we, rf_dr        register-file write enable and address
//   rf_wdata            register-file write data
//   nzp                 condition codes {N,Z,P}
//   done, illegal       one-cycle completion / rejection pulses
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new instruction
// READ  | source registers addressed, operands captured at the edge
// EXEC  | ALU driven from the operands, result captured at the edge
// WB    | result written back, done pulsed, nzp updated at the edge
// ERR   | instruction rejected, illegal pulsed, nothing written

module alu_op_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  rf_sr1,
  output logic [2:0]  rf_sr2,
  input  logic [15:0] rf_ra,
  input  logic [15:0] rf_rb,
  output logic [15:0] alu_ra,
  output logic [15:0] alu_rb,
  output logic [5:0]  alu_ir,
  output logic [1:0]  alu_control,
  input  logic [15:0] alu_result,
  output logic        rf_we,
  output logic [2:0]  rf_dr,
  output logic [15:0] rf_wdata,
  output logic [2:0]  nzp,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] ir_q;      // opcode is consumed at accept, only fields are kept
  logic [1:0]  ctrl_q;
  logic [15:0] op_a, op_b, result_q;
  logic [2:0]  nzp_q;

  logic        accept;
  logic        dec_legal;
  logic [1:0]  dec_ctrl;

  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = 2'b00;
    case (instr[15:12])
      4'b0001: begin dec_legal = 1'b1; dec_ctrl = 2'b01; end
      4'b0101: begin dec_legal = 1'b1; dec_ctrl = 2'b10; end
      4'b1001: begin dec_legal = 1'b1; dec_ctrl = 2'b11; end
      default: begin dec_legal = 1'b0; dec_ctrl = 2'b00; end
    endcase
`ifdef ALU_CTRL_STRICT_DECODE_EN
    if (dec_ctrl == 2'b11 && instr[5:0] != 6'b111111)
      dec_legal = 1'b0;
    if ((dec_ctrl == 2'b01 || dec_ctrl == 2'b10) && !instr[5] && instr[4:3] != 2'b00)
      dec_legal = 1'b0;
`endif
  end

  assign instr_ready = (state == S_IDLE) & ~reset;
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = dec_legal ? S_READ : S_ERR;
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ir_q     <= '0;
      ctrl_q   <= 2'b00;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
      nzp_q    <= 3'b010;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ir_q   <= instr[11:0];
        ctrl_q <= dec_ctrl;
      end
      if (state == S_READ) begin
        op_a <= rf_ra;
        op_b <= rf_rb;
      end
      if (state == S_EXEC)
        result_q <= alu_result;
      if (state == S_WB) begin
        if (result_q[15])          nzp_q <= 3'b100;
        else if (result_q == '0)   nzp_q <= 3'b010;
        else                       nzp_q <= 3'b001;
      end
    end
  end

  assign rf_sr1   = ir_q[8:6];
  assign rf_sr2   = ir_q[2:0];
  assign rf_dr    = ir_q[11:9];
  assign alu_ra   = op_a;
  assign alu_rb   = op_b;
  assign alu_ir   = ir_q[5:0];
  assign rf_wdata = result_q;
  assign nzp      = nzp_q;

  // Pulses are masked by reset so an abort in WB/ERR never leaks a write.
  always_comb begin
    alu_control = 2'b00;
    rf_we       = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_EXEC:  alu_control = ctrl_q;
      S_WB: begin
        alu_control = ctrl_q;
        rf_we       = ~reset;
        done        = ~reset;
      end
      S_ERR:   illegal = ~reset;
      default: alu_control = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_alu_op_ctrl.sv
module tb_alu_op_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  rf_sr1, rf_sr2, rf_dr, nzp;
  logic [15:0] rf_ra, rf_rb, alu_ra, alu_rb, alu_result, rf_wdata;
  logic [5:0]  alu_ir;
  logic [1:0]  alu_control;
  logic        rf_we, done, illegal;

  int tests = 0;
  int fails = 0;

  logic [15:0] regs [8];
  logic        pl_we = 1'b0;
  logic [2:0]  pl_idx = '0;
  logic [15:0] pl_val = '0;
  logic [2:0]  nzp_model;

  always #5 clk = ~clk;

  alu_op_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_sr1(rf_sr1), .rf_sr2(rf_sr2), .rf_ra(rf_ra), .rf_rb(rf_rb),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_ir(alu_ir), .alu_control(alu_control),
    .alu_result(alu_result), .rf_we(rf_we), .rf_dr(rf_dr), .rf_wdata(rf_wdata),
    .nzp(nzp), .done(done), .illegal(illegal)
  );

  // Register file and ALU environment
  assign rf_ra = regs[rf_sr1];
  assign rf_rb = regs[rf_sr2];

  always @(posedge clk) begin
    if (rf_we) regs[rf_dr] <= rf_wdata;
    if (pl_we) regs[pl_idx] <= pl_val;
  end

  always_comb begin
    logic [15:0] b;
    b = alu_ir[5] ? {{11{alu_ir[4]}}, alu_ir[4:0]} : alu_rb;
    case (alu_control)
      2'b00:   alu_result = alu_ra;
      2'b01:   alu_result = alu_ra + b;
      2'b10:   alu_result = alu_ra & b;
      default: alu_result = ~alu_ra;
    endcase
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clk);
    pl_idx = idx; pl_val = val; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic accept(input logic [15:0] ins);
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    chk("ready_at_offer", {15'd0, instr_ready}, 16'd1);
    tick();
    instr_valid = 1'b0;
  endtask

  function automatic logic [2:0] nzp_of(input logic [15:0] r);
    if (r[15]) return 3'b100;
    if (r == 16'd0) return 3'b010;
    return 3'b001;
  endfunction

  // Reference: ISA semantics straight from the instruction word and register array
  function automatic void model(input logic [15:0] ins, output bit ill, output logic [15:0] res);
    logic [15:0] a, b;
    a = regs[ins[8:6]];
    b = ins[5] ? {{11{ins[4]}}, ins[4:0]} : regs[ins[2:0]];
    ill = 1'b0;
    res = 16'd0;
    case (ins[15:12])
      4'd1:    res = a + b;
      4'd5:    res = a & b;
      4'd9:    res = ~a;
      default: ill = 1'b1;
    endcase
`ifdef ALU_CTRL_STRICT_DECODE_EN
    if (ins[15:12] == 4'd9 && ins[5:0] != 6'h3F) ill = 1'b1;
    if ((ins[15:12] == 4'd1 || ins[15:12] == 4'd5) && !ins[5] && ins[4:3] != 2'b00) ill = 1'b1;
`endif
  endfunction

  function automatic logic [1:0] ctrl_of(input logic [3:0] op);
    case (op)
      4'd1:    return 2'b01;
      4'd5:    return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Called right after accept(): sampling point is the first cycle after the accept edge.
  task automatic run_check(input logic [15:0] ins, input bit exp_ill,
                           input logic [15:0] exp_wdata, input string tag);
    if (exp_ill) begin
      chk({tag, "_illegal"}, {15'd0, illegal}, 16'd1);
      chk({tag, "_no_we_err"}, {15'd0, rf_we}, 16'd0);
      chk({tag, "_no_done_err"}, {15'd0, done}, 16'd0);
      tick();
      chk({tag, "_illegal_gone"}, {15'd0, illegal}, 16'd0);
      chk({tag, "_ready_after_err"}, {15'd0, instr_ready}, 16'd1);
      chk({tag, "_nzp_kept"}, {13'd0, nzp}, {13'd0, nzp_model});
    end else begin
      chk({tag, "_read_we"}, {15'd0, rf_we}, 16'd0);
      chk({tag, "_read_ctrl"}, {14'd0, alu_control}, 16'd0);
      tick();
      chk({tag, "_exec_ctrl"}, {14'd0, alu_control}, {14'd0, ctrl_of(ins[15:12])});
      chk({tag, "_exec_we"}, {15'd0, rf_we}, 16'd0);
      tick();
      chk({tag, "_wb_we"}, {15'd0, rf_we}, 16'd1);
      chk({tag, "_wb_done"}, {15'd0, done}, 16'd1);
      chk({tag, "_wb_dr"}, {13'd0, rf_dr}, {13'd0, ins[11:9]});
      chk({tag, "_wb_data"}, rf_wdata, exp_wdata);
      tick();
      nzp_model = nzp_of(exp_wdata);
      chk({tag, "_nzp"}, {13'd0, nzp}, {13'd0, nzp_model});
      chk({tag, "_idle_we"}, {15'd0, rf_we}, 16'd0);
      chk({tag, "_idle_ready"}, {15'd0, instr_ready}, 16'd1);
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [2:0]  p1_idx;
    logic [15:0] p1_val;
    logic [2:0]  p2_idx;
    logic [15:0] p2_val;
    bit          exp_ill;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'd0;
    nzp_model   = 3'b010;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'd0;

    vecs[0] = '{16'h147D, 3'd1, 16'h0005, 3'd1, 16'h0005, 1'b0, 16'h0002};
    vecs[1] = '{16'h5644, 3'd1, 16'h00F0, 3'd4, 16'h0F0F, 1'b0, 16'h0000};
    vecs[2] = '{16'h9A7F, 3'd1, 16'h0005, 3'd1, 16'h0005, 1'b0, 16'hFFFA};
    vecs[3] = '{16'h0000, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 16'h0000};
    vecs[4] = '{16'h1A83, 3'd2, 16'h7FFF, 3'd3, 16'h0001, 1'b0, 16'h8000};
    vecs[5] = '{16'hF025, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 16'h0000};
`ifdef ALU_CTRL_STRICT_DECODE_EN
    vecs[6] = '{16'h9A7E, 3'd1, 16'h1234, 3'd1, 16'h1234, 1'b1, 16'h0000};
    vecs[7] = '{16'h1A8B, 3'd2, 16'hFFFF, 3'd3, 16'h0001, 1'b1, 16'h0000};
`else
    vecs[6] = '{16'h9A7E, 3'd1, 16'h1234, 3'd1, 16'h1234, 1'b0, 16'hEDCB};
    vecs[7] = '{16'h1A8B, 3'd2, 16'hFFFF, 3'd3, 16'h0001, 1'b0, 16'h0000};
`endif

    tick();
    tick();
    chk("rst_ready_low", {15'd0, instr_ready}, 16'd0);
    chk("rst_nzp", {13'd0, nzp}, 16'h0002);
    chk("rst_we", {15'd0, rf_we}, 16'd0);
    chk("rst_ctrl", {14'd0, alu_control}, 16'd0);
    chk("rst_wdata", rf_wdata, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {15'd0, instr_ready}, 16'd1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      preload(vecs[i].p1_idx, vecs[i].p1_val);
      preload(vecs[i].p2_idx, vecs[i].p2_val);
      accept(vecs[i].ins);
      run_check(vecs[i].ins, vecs[i].exp_ill, vecs[i].exp_wdata, $sformatf("vec%0d", i));
    end

    // Illegal then immediate re-accept two cycles after the first accept
    preload(3'd1, 16'h0005);
    accept(16'h0000);
    chk("b2b_illegal", {15'd0, illegal}, 16'd1);
    tick();
    accept(16'h147D);
    run_check(16'h147D, 1'b0, 16'h0002, "b2b_add");

    // Held valid while busy must be ignored until IDLE
    accept(16'h147D);
    instr = 16'h0000;
    instr_valid = 1'b1;
    tick();
    tick();
    chk("busy_wdata", rf_wdata, 16'h0002);
    chk("busy_we", {15'd0, rf_we}, 16'd1);
    tick();
    chk("busy_nzp", {13'd0, nzp}, 16'h0001);
    chk("busy_ready_idle", {15'd0, instr_ready}, 16'd1);
    tick();
    instr_valid = 1'b0;
    chk("busy_then_illegal", {15'd0, illegal}, 16'd1);
    tick();
    chk("busy_illegal_gone", {15'd0, illegal}, 16'd0);

    // Reset during EXEC aborts the write
    preload(3'd2, 16'h1111);
    accept(16'h147D);
    tick();
    reset = 1'b1;
    chk("abort_exec_we", {15'd0, rf_we}, 16'd0);
    tick();
    chk("abort_ready_low", {15'd0, instr_ready}, 16'd0);
    chk("abort_nzp", {13'd0, nzp}, 16'h0002);
    chk("abort_we", {15'd0, rf_we}, 16'd0);
    reset = 1'b0;
    #1;
    chk("abort_ready_high", {15'd0, instr_ready}, 16'd1);
    tick();
    chk("abort_we_after", {15'd0, rf_we}, 16'd0);
    chk("abort_ready_still", {15'd0, instr_ready}, 16'd1);
    chk("abort_r2_kept", regs[2], 16'h1111);
    nzp_model = 3'b010;

    // Randomized against the ISA-level model
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ins, exp_res;
      logic [11:0] fields;
      logic [3:0]  op;
      bit          ill;
      fields = 12'($urandom);
      case ($urandom_range(0, 3))
        0: op = 4'd1;
        1: op = 4'd5;
        2: op = 4'd9;
        default: op = 4'($urandom_range(0, 15));
      endcase
      ins = {op, fields};
      preload(ins[8:6], 16'($urandom));
      if (ins[2:0] != ins[8:6] && $urandom_range(0, 1) == 1)
        preload(ins[2:0], 16'($urandom));
      model(ins, ill, exp_res);
      accept(ins);
      run_check(ins, ill, exp_res, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
